// File: rtl/subtraction_pkg.sv
// Shared types and sizing helpers for the serial 2-bit-per-cycle subtractor.
package subtraction_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   function automatic int digits_of(input int width);
      return width / 2;
   endfunction

   // Counter must be at least one bit even for a single-digit operand.
   function automatic int cnt_width(input int width);
      int c;
      c = $clog2(width / 2);
      return (c < 1) ? 1 : c;
   endfunction

endpackage

// File: rtl/sub_2bit_digit.sv
// One 2-bit subtractor slice: {bout, d} = a - b - bin as a 3-bit signed result.
module sub_2bit_digit (
   input  logic [1:0] a,
   input  logic [1:0] b,
   input  logic       bin,
   output logic [1:0] d,
   output logic       bout
);

   logic [2:0] diff;

   assign diff = {1'b0, a} - {1'b0, b} - {2'b00, bin};
   assign d    = diff[1:0];
   assign bout = diff[2];

endmodule

// File: rtl/subtraction_2bits_serial.sv
// Serial subtractor: D = A - B - bin, one 2-bit digit per clock, LSB digit first,
// with start/busy/done handshake and registered, glitch-free result outputs.
module subtraction_2bits_serial
   import subtraction_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             start,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out_d,
   output logic             bout
);

   localparam int DIGITS = digits_of(WIDTH);
   localparam int CW     = cnt_width(WIDTH);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt;
   logic [CW-1:0]    cnt;
   logic             borrow;
   logic [1:0]       dig_d;
   logic             dig_bout;
   logic             accept, last;

   sub_2bit_digit u_digit (
      .a    (a_sh[1:0]),
      .b    (b_sh[1:0]),
      .bin  (borrow),
      .d    (dig_d),
      .bout (dig_bout)
   );

   assign accept  = start && (state == IDLE || state == DONE);
   assign last    = (cnt == CW'(DIGITS - 1));
   assign busy    = (state == RUN);
   assign done    = (state == DONE);
   // New digit enters at the top; after DIGITS shifts the word is aligned.
   assign res_nxt = (res_sh >> 2) | (WIDTH'(dig_d) << (WIDTH - 2));

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         cnt    <= '0;
         borrow <= 1'b0;
         out_d  <= '0;
         bout   <= 1'b0;
      end else if (accept) begin
         a_sh   <= in_a;
         b_sh   <= in_b;
         borrow <= bin;
         cnt    <= '0;
      end else if (state == RUN) begin
         a_sh   <= a_sh >> 2;
         b_sh   <= b_sh >> 2;
         borrow <= dig_bout;
         res_sh <= res_nxt;
         cnt    <= cnt + CW'(1);
         if (last) begin
            out_d <= res_nxt;
            bout  <= dig_bout;
         end
      end
   end

endmodule

// File: tb/tb_subtraction_2bits_serial.sv
// Scoreboard bench for subtraction_2bits_serial (WIDTH=16): driver pushes expected
// results from an arithmetic model, a monitor pops and compares on every done pulse.
module tb_subtraction_2bits_serial;

   localparam int W      = 16;
   localparam int DIGITS = 8;

   logic          Clock = 1'b0;
   logic          Reset = 1'b1;
   logic          start = 1'b0;
   logic [W-1:0]  in_a  = '0;
   logic [W-1:0]  in_b  = '0;
   logic          bin   = 1'b0;
   logic          busy, done, bout;
   logic [W-1:0]  out_d;

   subtraction_2bits_serial #(.WIDTH(W)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .start (start),
      .in_a  (in_a),
      .in_b  (in_b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .out_d (out_d),
      .bout  (bout)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic [W-1:0] d;
      logic         bo;
      int           acc;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   n_pass = 0;
   int   n_total = 0;
   int   cyc = 0;
   int   done_cyc = 0;
   int   prev_done_cyc = 0;
   int   n_done = 0;

   always @(posedge Clock) cyc <= cyc + 1;

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic bi, input int acc);
      exp_t m;
      int   diff;
      diff  = int'(a) - int'(b) - int'(bi);
      m.d   = diff[W-1:0];
      m.bo  = (diff < 0);
      m.acc = acc;
      return m;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   always @(negedge Clock) begin
      if (!Reset && done) begin
         prev_done_cyc = done_cyc;
         done_cyc      = cyc;
         n_done++;
         check("done_busy_excl", {31'b0, busy}, 32'd0);
         if (q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
         else begin
            mon_e = q.pop_front();
            check("out_d", {16'b0, out_d}, {16'b0, mon_e.d});
            check("bout", {31'b0, bout}, {31'b0, mon_e.bo});
            check("latency", cyc - mon_e.acc, DIGITS);
         end
      end
   end

   // Called at a negedge with the DUT in IDLE or DONE; returns at the negedge after E0.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        input bit expect_result);
      in_a  = a;
      in_b  = b;
      bin   = bi;
      start = 1'b1;
      if (expect_result) q.push_back(model(a, b, bi, cyc + 1));
      @(posedge Clock);
      #1;
      start = 1'b0;
      in_a  = W'($urandom);
      in_b  = W'($urandom);
      bin   = 1'($urandom);
      @(negedge Clock);
   endtask

   task automatic wait_quiet();
      int k;
      k = 0;
      while ((busy || done || q.size() != 0) && k < 100) begin
         @(negedge Clock);
         k++;
      end
      check("drain_timeout", {31'b0, k < 100}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bc;
      int k;
      int nd;
      logic [W-1:0] ra, rb;

      #12;
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_out_d", {16'b0, out_d}, 32'd0);
      check("rst_bout", {31'b0, bout}, 32'd0);
      @(negedge Clock);
      Reset = 1'b0;
      @(negedge Clock);

      // Basic op and busy duration
      issue(16'h1234, 16'h0034, 1'b0, 1'b1);
      bc = 0;
      while (busy && bc < 50) begin
         bc++;
         @(negedge Clock);
      end
      check("busy_len", bc, DIGITS);
      wait_quiet();

      // Underflow; previous result must hold until completion
      issue(16'h0000, 16'h0001, 1'b0, 1'b1);
      for (int i = 0; i < DIGITS; i++) begin
         check("out_d_hold", {16'b0, out_d}, 32'h1200);
         @(negedge Clock);
      end
      wait_quiet();

      issue(16'h0005, 16'h0003, 1'b1, 1'b1);
      wait_quiet();
      issue(16'h8000, 16'h8000, 1'b1, 1'b1);
      wait_quiet();

      // start pulsed mid-RUN is ignored
      nd = n_done;
      issue(16'hBEEF, 16'h1111, 1'b0, 1'b1);
      repeat (3) @(negedge Clock);
      in_a = 16'h0001; in_b = 16'h0002; bin = 1'b1; start = 1'b1;
      @(negedge Clock);
      start = 1'b0;
      wait_quiet();
      check("one_done_pulse", n_done - nd, 1);

      // start held through DONE: back-to-back acceptance
      issue(16'hABCD, 16'h1234, 1'b0, 1'b1);
      in_a = 16'h0F0F; in_b = 16'hF0F0; bin = 1'b1; start = 1'b1;
      k = 0;
      while (!done && k < 50) begin
         @(negedge Clock);
         k++;
      end
      check("b2b_done_seen", {31'b0, done}, 32'd1);
      q.push_back(model(16'h0F0F, 16'hF0F0, 1'b1, cyc + 1));
      @(posedge Clock);
      #1;
      start = 1'b0;
      @(negedge Clock);
      wait_quiet();
      check("b2b_spacing", done_cyc - prev_done_cyc, DIGITS + 1);

      // Async reset mid-RUN aborts with no done pulse
      nd = n_done;
      issue(16'h7777, 16'h0123, 1'b0, 1'b0);
      repeat (3) @(negedge Clock);
      #2;
      Reset = 1'b1;
      #1;
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_done", {31'b0, done}, 32'd0);
      check("abort_out_d", {16'b0, out_d}, 32'd0);
      check("abort_bout", {31'b0, bout}, 32'd0);
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      repeat (12) @(negedge Clock);
      check("abort_no_done", n_done - nd, 0);
      issue(16'h4321, 16'h1234, 1'b1, 1'b1);
      wait_quiet();

      // Randomized operations, including operand corner values
      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 3))
            0:       ra = 16'h0000;
            1:       ra = 16'hFFFF;
            default: ra = W'($urandom);
         endcase
         case ($urandom_range(0, 3))
            0:       rb = 16'h0000;
            1:       rb = 16'hFFFF;
            default: rb = W'($urandom);
         endcase
         issue(ra, rb, 1'($urandom), 1'b1);
         wait_quiet();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
